// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared CPU pipeline definitions: register-id width, hazard
//             controller state encoding and the load-use detect helper.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Width of an architectural register identifier
    localparam int REG_ID_W = 4;

    // Width of the mul/div occupancy down-counter
    localparam int MD_CNT_W = 4;

    // Hazard controller state encoding (2'b11 is unreachable)
    typedef enum logic [1:0] {
        HC_RUN     = 2'b00,
        HC_MD_WAIT = 2'b01,
        HC_MD_DONE = 2'b10
    } hc_state_t;

    // A load in EX whose destination feeds either ID source is a hazard.
    // Register 0 is hard-wired and never creates a dependency.
    function automatic logic is_load_use(
        input logic                mem_read,
        input logic [REG_ID_W-1:0] rd_ex,
        input logic [REG_ID_W-1:0] rs1_id,
        input logic [REG_ID_W-1:0] rs2_id
    );
        return mem_read && (rd_ex != '0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_timer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_timer
//  Brief    : Loadable down-counter tracking remaining mul/div wait cycles.
//             Decrement stops at 1 so the counter never wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_timer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [MD_CNT_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                one_o
);

    logic [MD_CNT_W-1:0] count_q;

    // Load takes priority over decrement; decrement holds at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q > MD_CNT_W'(1))) begin
            count_q <= count_q - MD_CNT_W'(1);
        end
    end

    assign one_o = (count_q == MD_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_controller
//  Brief    : Pipeline hazard controller: branch flush, load-use stall and
//             multi-cycle mul/div stall sequencing.
//             Optional stall performance counter enabled by defining
//             HAZARD_PERF_COUNTERS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ID_W-1:0] registerOP1ID,
    input  logic [REG_ID_W-1:0] registerOP2ID,
    input  logic [REG_ID_W-1:0] registerOP1EX,
    input  logic                memReadEX,
    input  logic                muldivStartEX,
    input  logic                branchTakenEX,
    output logic                pcWrite,
    output logic                ifidWrite,
    output logic                idexWrite,
    output logic                ifidFlush,
    output logic                idexBubble,
    output logic                exmemBubble,
    output logic                muldivDone,
    output logic [1:0]          state,
    output logic [15:0]         stallCount
);

    // The start cycle and the done cycle are part of the occupancy, so the
    // wait phase covers the remaining MULDIV_CYCLES-2 cycles.
    localparam logic [MD_CNT_W-1:0] c_MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 2);

    hc_state_t state_q;
    hc_state_t state_d;
    logic      w_timer_load;
    logic      w_timer_dec;
    logic      w_timer_one;
    logic      w_load_use;

    assign w_load_use = is_load_use(memReadEX, registerOP1EX, registerOP1ID, registerOP2ID);

    muldiv_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_timer_load),
        .load_val_i (c_MD_LOAD),
        .dec_i      (w_timer_dec),
        .one_o      (w_timer_one)
    );

    // Next-state and same-cycle control outputs; reset forces RUN defaults
    always_comb begin
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        idexWrite    = 1'b1;
        ifidFlush    = 1'b0;
        idexBubble   = 1'b0;
        exmemBubble  = 1'b0;
        muldivDone   = 1'b0;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        state_d      = HC_RUN;
        if (!rst) begin
            case (state_q)
                HC_RUN: begin
                    if (branchTakenEX) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (muldivStartEX) begin
                        pcWrite      = 1'b0;
                        ifidWrite    = 1'b0;
                        idexWrite    = 1'b0;
                        exmemBubble  = 1'b1;
                        w_timer_load = 1'b1;
                        state_d      = (MULDIV_CYCLES == 2) ? HC_MD_DONE : HC_MD_WAIT;
                    end else if (w_load_use) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                    end
                end
                HC_MD_WAIT: begin
                    pcWrite     = 1'b0;
                    ifidWrite   = 1'b0;
                    idexWrite   = 1'b0;
                    exmemBubble = 1'b1;
                    w_timer_dec = 1'b1;
                    state_d     = w_timer_one ? HC_MD_DONE : HC_MD_WAIT;
                end
                HC_MD_DONE: begin
                    muldivDone = 1'b1;
                    if (branchTakenEX) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end
                end
                default: begin
                    state_d = HC_RUN;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [15:0] stall_cnt_q;

    // Count stalled fetch cycles, saturating at the maximum
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!pcWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stallCount = stall_cnt_q;
`else
    assign stallCount = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_controller
//  Brief    : Self-checking bench for hazard_controller with a cycle-count
//             reference model, directed scenarios and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int MDC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  registerOP1ID = '0;
    logic [3:0]  registerOP2ID = '0;
    logic [3:0]  registerOP1EX = '0;
    logic        memReadEX = 1'b0;
    logic        muldivStartEX = 1'b0;
    logic        branchTakenEX = 1'b0;
    logic        pcWrite, ifidWrite, idexWrite, ifidFlush, idexBubble, exmemBubble, muldivDone;
    logic [1:0]  state;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    // Model: cycles of mul/div occupancy still to come after this one (0 = idle)
    int md_remain = 0;
    int exp_stall = 0;

    hazard_controller #(.MULDIV_CYCLES(MDC)) dut (
        .clk           (clk),
        .rst           (rst),
        .registerOP1ID (registerOP1ID),
        .registerOP2ID (registerOP2ID),
        .registerOP1EX (registerOP1EX),
        .memReadEX     (memReadEX),
        .muldivStartEX (muldivStartEX),
        .branchTakenEX (branchTakenEX),
        .pcWrite       (pcWrite),
        .ifidWrite     (ifidWrite),
        .idexWrite     (idexWrite),
        .ifidFlush     (ifidFlush),
        .idexBubble    (idexBubble),
        .exmemBubble   (exmemBubble),
        .muldivDone    (muldivDone),
        .state         (state),
        .stallCount    (stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs packed as {pcW,ifidW,idexW,flush,idexB,exmemB,done,state[1:0]}
    function automatic logic [8:0] model_out();
        logic pw, iw, xw, fl, bb, eb, dn;
        logic [1:0] st;
        logic lu;
        pw = 1; iw = 1; xw = 1; fl = 0; bb = 0; eb = 0; dn = 0;
        st = (md_remain == 0) ? 2'b00 : (md_remain == 1) ? 2'b10 : 2'b01;
        lu = memReadEX && registerOP1EX != 0 &&
             (registerOP1EX == registerOP1ID || registerOP1EX == registerOP2ID);
        if (!rst) begin
            if (md_remain == 0) begin
                if (branchTakenEX) begin fl = 1; bb = 1; end
                else if (muldivStartEX) begin pw = 0; iw = 0; xw = 0; eb = 1; end
                else if (lu) begin pw = 0; iw = 0; bb = 1; end
            end else if (md_remain > 1) begin
                pw = 0; iw = 0; xw = 0; eb = 1;
            end else begin
                dn = 1;
                if (branchTakenEX) begin fl = 1; bb = 1; end
            end
        end
        return {pw, iw, xw, fl, bb, eb, dn, st};
    endfunction

    function automatic logic [8:0] dut_out();
        return {pcWrite, ifidWrite, idexWrite, ifidFlush, idexBubble, exmemBubble, muldivDone, state};
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance model at the edge
    task automatic cyc(input logic r, input logic b, input logic m, input logic mr,
                       input logic [3:0] rex, input logic [3:0] r1, input logic [3:0] r2);
        logic [8:0] e;
        @(negedge clk);
        rst = r; branchTakenEX = b; muldivStartEX = m; memReadEX = mr;
        registerOP1EX = rex; registerOP1ID = r1; registerOP2ID = r2;
        #1;
        e = model_out();
        chk("outputs", 32'(dut_out()), 32'(e));
        chk("stallCount", 32'(stallCount), 32'(exp_stall));
        @(posedge clk);
        if (rst) begin
            md_remain = 0;
            exp_stall = 0;
        end else begin
`ifdef HAZARD_PERF_COUNTERS_EN
            if (!e[8] && exp_stall < 65535) exp_stall++;
`endif
            if (md_remain == 0) begin
                if (!branchTakenEX && muldivStartEX) md_remain = MDC - 1;
            end else begin
                md_remain--;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        // Initial reset: DUT state is unknown before the first edge, so not checked
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset held with hazards active: RUN defaults
        cyc(1, 0, 0, 1, 4'd5, 4'd5, 4'd0);
        cyc(1, 1, 1, 1, 4'd5, 4'd0, 4'd5);
        idle();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pcWrite", 32'(pcWrite), 32'd1);

        // Load-use on second operand, then cleared inputs
        cyc(0, 0, 0, 1, 4'd5, 4'd0, 4'd5);
        idle();
        // Register 0 never stalls
        cyc(0, 0, 0, 1, 4'd0, 4'd0, 4'd0);
        // Load without dependency, and non-load with dependency
        cyc(0, 0, 0, 1, 4'd3, 4'd4, 4'd6);
        cyc(0, 0, 0, 0, 4'd7, 4'd7, 4'd7);

        // Mul/div held for MDC cycles, then return to RUN
        repeat (MDC) cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
        idle();
        chk("md_back_to_run", 32'(state), 32'd0);

        // Branch beats mul/div and load-use
        cyc(0, 1, 1, 1, 4'd2, 4'd2, 4'd0);
        idle();

        // Branch during the done cycle is honoured
        cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
        repeat (MDC - 2) cyc(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
        cyc(0, 1, 1, 1, 4'd9, 4'd9, 4'd9);
        idle();

        // Reset in the second wait cycle aborts the operation
        cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
        cyc(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
        cyc(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
        idle();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_stallCount", 32'(stallCount), 32'd0);

        // Perf: 3 load-use stalls plus one full mul/div
        cyc(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
        cyc(0, 0, 0, 1, 4'd1, 4'd1, 4'd0);
        idle();
        cyc(0, 0, 0, 1, 4'd2, 4'd0, 4'd2);
        cyc(0, 0, 0, 1, 4'd3, 4'd3, 4'd3);
        repeat (MDC) cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
        idle();
`ifdef HAZARD_PERF_COUNTERS_EN
        chk("perf_total", 32'(stallCount), 32'd6);
`else
        chk("perf_total", 32'(stallCount), 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 39) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 0,
                4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, meaning total EX-occupancy cycles of a mul/div op (legal 2..16).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports registerOP1ID, registerOP2ID  in  4 each  source register ids of the instruction in ID.
REQ-005 SHALL have port registerOP1EX  in  4  destination register id of the instruction in EX.
REQ-006 SHALL have ports memReadEX, muldivStartEX, branchTakenEX  in  1 each  EX instruction is a load / is mul-div / is a taken branch.
REQ-007 SHALL have ports pcWrite, ifidWrite, idexWrite  out  1 each  write enables for the PC, IF/ID and ID/EX registers.
REQ-008 SHALL have ports ifidFlush, idexBubble, exmemBubble  out  1 each  zero the IF/ID register / insert NOP into ID/EX / insert NOP into EX/MEM.
REQ-009 SHALL have ports muldivDone  out  1  (final mul/div cycle), state  out  2  (debug), stallCount  out  16  (perf counter).

Function
REQ-010 SHALL implement FSM states RUN=2'b00, MD_WAIT=2'b01, MD_DONE=2'b10; 2'b11 is unreachable and recovers to RUN next cycle with all outputs at RUN defaults; state output = current state.
REQ-011 Default outputs (RUN, no event): pcWrite=ifidWrite=idexWrite=1, all other outputs 0.
REQ-012 Priority within RUN: branchTakenEX > muldivStartEX > load-use.
REQ-013 RUN + branchTakenEX: same-cycle ifidFlush=1, idexBubble=1, pcWrite=1; state stays RUN.
REQ-014 RUN + muldivStartEX (no branch): same-cycle pcWrite=ifidWrite=idexWrite=0, exmemBubble=1; counter loads MULDIV_CYCLES-2; next state MD_WAIT, or MD_DONE if MULDIV_CYCLES=2.
REQ-015 MD_WAIT: pcWrite=ifidWrite=idexWrite=0, exmemBubble=1; counter decrements each cycle; when counter==1, next state MD_DONE.
REQ-016 MD_DONE: muldivDone=1, enables as RUN defaults, exmemBubble=0; muldivStartEX, memReadEX ignored; branchTakenEX honoured as in REQ-013; next state RUN.
REQ-017 Load-use (RUN, no branch/muldiv): memReadEX=1, registerOP1EX!=0, and registerOP1EX equals registerOP1ID or registerOP2ID -> same-cycle pcWrite=ifidWrite=0, idexBubble=1; purely combinational, one cycle per hazard.
REQ-018 Register 0 SHALL never cause a load-use stall.
REQ-019 In MD_WAIT, all event inputs SHALL be ignored.
REQ-020 Counter width SHALL be 4 bits; no wrap — it never decrements below 1.

Reset
REQ-021 rst=1 at a rising edge SHALL force state=RUN, counter=0, stallCount=0, overriding any in-progress mul/div; outputs SHALL reflect RUN from the next cycle.
REQ-022 While rst is held, outputs SHALL be RUN defaults with hazard inputs ignored.

Configuration
REQ-023 With macro HAZARD_PERF_COUNTERS_EN defined, stallCount SHALL increment on every non-reset cycle with pcWrite=0, saturating at 16'hFFFF.
REQ-024 Without HAZARD_PERF_COUNTERS_EN, stallCount SHALL be constant 0 and no counter flops synthesized; all other behaviour identical.

Structure
REQ-025 Shared package cpu_pkg SHALL hold the 4-bit register-id width constant and the hc_state_t state encoding from REQ-010.
REQ-026 The mul/div down-counter SHALL be a sub-module muldiv_timer (load, decrement, counter==1 flag); everything else stays in hazard_controller.

Verification
REQ-027 Load-use: memReadEX=1, registerOP1EX=5, registerOP2ID=5 -> one cycle pcWrite=0, ifidWrite=0, idexBubble=1; next cycle (inputs cleared) defaults.
REQ-028 Reg 0: memReadEX=1, registerOP1EX=0, registerOP1ID=0 -> no stall.
REQ-029 Mul/div MULDIV_CYCLES=4: muldivStartEX held 4 cycles -> stall in cycles 1-3 (RUN, MD_WAIT, MD_WAIT), muldivDone=1 in cycle 4, state 00,01,01,10, then 00.
REQ-030 Simultaneous: branchTakenEX=1, muldivStartEX=1, load-use active -> only flush (ifidFlush=1, idexBubble=1), no stall, state RUN.
REQ-031 Reset mid-op: rst=1 in second MD_WAIT cycle -> state=00, enables=1 next cycle, stallCount=0.
REQ-032 Perf (macro on): 3 load-use stalls + one 4-cycle mul/div -> stallCount=6; macro off -> 0.
